// File: rtl/device_bus_pkg.sv
// Shared definitions for the device bus: arbiter state encoding, bus widths
// and the control-region address decode used by the devices block.
package device_bus_pkg;

  localparam int DEV_ADDR_WIDTH = 16;
  localparam int DEV_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } bus_state_t;

  // Upper nibble 0 selects the control region, where the device id moves down a nibble.
  localparam logic [3:0] CTRL_REGION_NIBBLE = 4'h0;
  localparam int         CTRL_ID_MSB        = 11;
  localparam int         CTRL_ID_LSB        = 4;
  localparam int         DEV_ID_MSB         = 15;
  localparam int         DEV_ID_LSB         = 8;

  function automatic logic [7:0] dev_id(input logic [DEV_ADDR_WIDTH-1:0] addr);
    if (addr[15:12] == CTRL_REGION_NIBBLE)
      return addr[CTRL_ID_MSB:CTRL_ID_LSB];
    else
      return addr[DEV_ID_MSB:DEV_ID_LSB];
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request bit at or after ptr, wrapping at
// NUM_REQ. Purely combinational.
module rr_priority_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         winner,
  output logic               any_req
);

  logic [3:0] req_pad;

  assign req_pad = 4'(req);
  assign any_req = |req;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    logic [2:0] idx;
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + 3'(i);
      if (idx >= 3'(NUM_REQ))
        idx = idx - 3'(NUM_REQ);
      if (req_pad[idx[1:0]])
        winner = idx[1:0];
    end
  end

endmodule

// File: rtl/device_bus_arbiter.sv
// Round-robin arbiter sharing the device bus between NUM_REQ requesters,
// one access per grant, absorbing the registered read latency of the devices.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner's access
// ACCESS | address/data on the bus; write_enable high for writes only
// WAIT   | read only: device data_out becomes valid and is captured into rdata
// DONE   | ack pulse to the granted requester; round-robin pointer advances
module device_bus_arbiter
  import device_bus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = DEV_DATA_WIDTH
) (
  input  logic                          cpu_clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    grant_id,
  output logic                          busy,
  output logic                          dev_write_enable,
  output logic [DATA_WIDTH-1:0]         dev_address,
  output logic [DATA_WIDTH-1:0]         dev_data_in,
  input  logic [DATA_WIDTH-1:0]         dev_data_out
);

  bus_state_t              state;
  logic [1:0]              rr_ptr;
  logic [1:0]              winner;
  logic                    any_req;
  logic                    win_we;
  logic [DATA_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_data;
  logic [NUM_REQ-1:0]      grant_onehot;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req),
    .ptr     (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    win_we   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 2'(i)) begin
        win_we   = req_we[i];
        win_addr = req_address[i*DATA_WIDTH +: DATA_WIDTH];
        win_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant_onehot[i] = (grant_id == 2'(i));
  end

  // ack is set on entry to DONE so it is a registered one-cycle pulse.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      ack              <= '0;
      rdata            <= '0;
      grant_id         <= '0;
      busy             <= 1'b0;
      dev_write_enable <= 1'b0;
      dev_address      <= '0;
      dev_data_in      <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id         <= winner;
            dev_address      <= win_addr;
            dev_data_in      <= win_data;
            dev_write_enable <= win_we;
            busy             <= 1'b1;
            state            <= ACCESS;
          end
        end
        ACCESS: begin
          dev_write_enable <= 1'b0;
          if (dev_write_enable) begin
            ack   <= grant_onehot;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          rdata <= dev_data_out;
          ack   <= grant_onehot;
          state <= DONE;
        end
        DONE: begin
          rr_ptr <= (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/device_bus_arbiter.md
Name: device_bus_arbiter

Overview:
Shares the single device bus (write_enable/address/data_in out, registered data_out back) between NUM_REQ requesters, e.g. CPU and a DMA/debug engine.
- Arbitration is round-robin; each grant covers exactly one device access.
- Sits between the requesters and the devices block. The devices block is unchanged: its data_out is registered, so reads carry a one-cycle device latency that this block absorbs.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_WIDTH, 16, bus data/address width

Ports:
cpu_clock  input  1  single clock
reset_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester access request, held high until ack
req_we  input  NUM_REQ  per-requester write flag, valid while req
req_address  input  NUM_REQ*16  packed addresses, slice i = requester i
req_data_in  input  NUM_REQ*16  packed write data
ack  output  NUM_REQ  one-cycle completion pulse per requester
rdata  output  16  read data, valid in the ack cycle of a read
grant_id  output  2  index of current/last granted requester
busy  output  1  high in any state but IDLE
dev_write_enable  output  1  to devices write_enable
dev_address  output  16  to devices address
dev_data_in  output  16  to devices data_in
dev_data_out  input  16  from devices data_out, valid one cycle after address presented

Behaviour:
- Reset (async, reset_n low): state IDLE; ack=0; rdata=0; grant_id=0; busy=0; dev_write_enable=0; dev_address=0; dev_data_in=0; rr pointer=0. Any in-flight access is abandoned and no ack is issued.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req bit is set, pick the winner by round-robin starting at the rr pointer (the first set bit at or after the pointer, wrapping at NUM_REQ).
  - Register winner's address/data/we into dev_* and winner into grant_id; go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS (1 cycle):
  - dev_address and dev_data_in are held.
  - dev_write_enable=1 only if the latched access is a write; it must be high for exactly this one cycle.
  - Write goes to DONE; read goes to WAIT.
- WAIT (reads only, 1 cycle): dev_address held; dev_write_enable=0. Capture dev_data_out into rdata at the end of the cycle. Go to DONE.
- DONE (1 cycle):
  - ack[grant_id]=1, all other ack bits 0. rdata is valid for reads; for writes rdata holds its previous value.
  - rr pointer := (grant_id+1) mod NUM_REQ. Go to IDLE.
- Latency from req sampled in IDLE at cycle 0:
  - write: dev_write_enable in cycle 1, ack in cycle 2.
  - read: dev_data_out sampled at end of cycle 2, ack + rdata in cycle 3.
- Requester rules:
  - req must stay asserted and its we/address/data stable until ack.
  - The requester deasserts req, or presents a new access, in the cycle after ack.
  - req seen during DONE is ignored; the next arbitration happens in IDLE. Minimum spacing between grants is therefore 1 idle cycle.
- Request withdrawn before grant: no effect. Withdrawn after grant: the access still completes and is acked (protocol violation, not flagged).
- Simultaneous requests: with pointer 0 and req=2'b11, requester 0 wins, then requester 1, then 0, and so on. A lone requester is granted back-to-back, every 3 cycles for writes and 4 for reads.
- dev_address is held after an access (not cleared) until the next grant; dev_write_enable is 0 outside ACCESS.
- Address decode is not done here; addresses pass through unmodified.

Decomposition:
Shared package device_bus_pkg holds:
- the state enum (IDLE=0, ACCESS=1, WAIT=2, DONE=3)
- DEV_ADDR_WIDTH=16 and DEV_DATA_WIDTH=16
- the control-region decode constants (upper nibble 0 = control; device id in [11:4], otherwise in [15:8]), shared with the devices block.

One sub-module, rr_priority_picker: combinational, inputs req vector and pointer, outputs winner index and any_req.

Test Plan:
- Reset mid-read: assert reset_n=0 during WAIT → all outputs return to reset values and no ack is issued; after release, req[0] read completes normally.
- Single write: req[0]=1, we=1, addr=16'h0200, data=16'h0041 → dev_write_enable high for exactly cycle 1 with addr 16'h0200 and data 16'h0041; ack[0] in cycle 2; busy high cycles 1-2.
- Single read: req[1]=1, we=0, addr=16'h0021; device model returns 16'h0100 one cycle after the address → ack[1] and rdata=16'h0100 in cycle 3; dev_write_enable never high.
- Contention: req=2'b11, both reads, held continuously → grant order 0,1,0,1; each ack is in its own cycle, spaced 4 cycles apart; grant_id matches each ack.
- Back-to-back single requester: req[0] writes re-asserted immediately after each ack, 8 accesses → 8 acks at a 3-cycle period; requester 1 idle and never acked.
- Starvation check: requester 0 issues writes continuously; req[1] rises mid-stream → requester 1 is granted at the next IDLE and acked within 4 cycles of that IDLE.
